redirect_controller: RTL and testbench

//   Sequences the pipeline front end around control-flow redirects and hazards in the 5-stage RISC-V core.

---
 rtl/redirect_controller_if.sv | 26 ++
 rtl/redirect_controller.sv | 111 +++++++++++
 tb/tb_redirect_controller.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/redirect_controller_if.sv
// Front-end control bundle between the hazard/branch logic and the redirect controller.
// The pipeline side drives the master modport. The controller uses the slave modport.
interface redirect_controller_if #(
  parameter int CNT_W = 16
) ();
  logic [1:0]       PCSrcE;
  logic             lwStall;
  logic             imem_ready;
  logic [1:0]       PCSelF;
  logic             StallF;
  logic             StallD;
  logic             FlushD;
  logic             FlushE;
  logic             squash_busy;
  logic [CNT_W-1:0] redirect_cnt;

  modport master (
    output PCSrcE, lwStall, imem_ready,
    input  PCSelF, StallF, StallD, FlushD, FlushE, squash_busy, redirect_cnt
  );

  modport slave (
    input  PCSrcE, lwStall, imem_ready,
    output PCSelF, StallF, StallD, FlushD, FlushE, squash_busy, redirect_cnt
  );
endinterface

// File: rtl/redirect_controller.sv
// Sequences PC select, stall and flush controls around Execute-stage redirects,
// load-use hazards and instruction-memory back-pressure, with a wrong-path squash window.
module redirect_controller #(
  parameter int SQUASH_N = 1,
  parameter int CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  redirect_controller_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN    = 2'b01,
    SQUASH = 2'b10
  } state_t;

  localparam logic [3:0] SQ_INIT = 4'(SQUASH_N);

  state_t           state_q, state_d;
  logic [3:0]       sq_cnt_q, sq_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       redir;
  logic       in_squash;
  logic       state_legal;
  logic [1:0] pcsel;
  logic       stall_f, stall_d, flush_d, flush_e;

  assign redir       = (bus.PCSrcE == 2'b01) || (bus.PCSrcE == 2'b10);
  assign in_squash   = (state_q == SQUASH);
  assign state_legal = (state_q == RUN) || (state_q == SQUASH);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= RUN;
      sq_cnt_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      sq_cnt_q <= sq_cnt_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sq_cnt_d = sq_cnt_q;
    pcsel    = 2'b00;
    stall_f  = 1'b0;
    stall_d  = 1'b0;
    flush_d  = 1'b0;
    flush_e  = 1'b0;

    if (redir) begin
      // Target always loads; the stalled Decode instruction is flushed, so lwStall is moot.
      pcsel   = bus.PCSrcE;
      flush_d = 1'b1;
      flush_e = 1'b1;
      if (SQUASH_N > 0) begin
        state_d  = SQUASH;
        sq_cnt_d = SQ_INIT;
      end else begin
        state_d  = RUN;
        sq_cnt_d = '0;
      end
    end else begin
      if (!bus.imem_ready) begin
        stall_f = 1'b1;
        flush_d = 1'b1;
        flush_e = bus.lwStall;
      end else begin
        if (bus.lwStall) begin
          stall_f = 1'b1;
          flush_e = 1'b1;
          stall_d = !in_squash;
        end
        if (in_squash) begin
          // Each accepted fetch in the window is wrong-path and is discarded.
          flush_d = 1'b1;
          if (sq_cnt_q > 4'd1) begin
            sq_cnt_d = sq_cnt_q - 4'd1;
          end else begin
            sq_cnt_d = '0;
            state_d  = RUN;
          end
        end
      end
      if (!state_legal) begin
        state_d  = RUN;
        sq_cnt_d = '0;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (redir && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Reset forces bubbles into Decode and Execute regardless of inputs.
  assign bus.PCSelF       = rst ? pcsel   : 2'b00;
  assign bus.StallF       = rst ? stall_f : 1'b0;
  assign bus.StallD       = rst ? stall_d : 1'b0;
  assign bus.FlushD       = rst ? flush_d : 1'b1;
  assign bus.FlushE       = rst ? flush_e : 1'b1;
  assign bus.squash_busy  = in_squash;
  assign bus.redirect_cnt = cnt_q;

endmodule

// File: tb/tb_redirect_controller.sv
// Scoreboard bench for redirect_controller: three instances cover SQUASH_N=1, SQUASH_N=2 and CNT_W=2.
module tb_redirect_controller;

  logic       clk;
  logic       rst;
  logic [1:0] pcsrc;
  logic       lw;
  logic       rdy;

  int checks;
  int errors;

  logic [6:0] sb_q[$];

  redirect_controller_if #(.CNT_W(16)) if_a ();
  redirect_controller_if #(.CNT_W(16)) if_b ();
  redirect_controller_if #(.CNT_W(2))  if_c ();

  assign if_a.PCSrcE = pcsrc;  assign if_a.lwStall = lw;  assign if_a.imem_ready = rdy;
  assign if_b.PCSrcE = pcsrc;  assign if_b.lwStall = lw;  assign if_b.imem_ready = rdy;
  assign if_c.PCSrcE = pcsrc;  assign if_c.lwStall = lw;  assign if_c.imem_ready = rdy;

  redirect_controller #(.SQUASH_N(1), .CNT_W(16)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
  redirect_controller #(.SQUASH_N(2), .CNT_W(16)) dut_b (.clk(clk), .rst(rst), .bus(if_b));
  redirect_controller #(.SQUASH_N(1), .CNT_W(2))  dut_c (.clk(clk), .rst(rst), .bus(if_c));

  // {PCSelF[1:0], StallF, StallD, FlushD, FlushE, squash_busy}
  logic [6:0] obs_a, obs_b, obs_c;
  assign obs_a = {if_a.PCSelF, if_a.StallF, if_a.StallD, if_a.FlushD, if_a.FlushE, if_a.squash_busy};
  assign obs_b = {if_b.PCSelF, if_b.StallF, if_b.StallD, if_b.FlushD, if_b.FlushE, if_b.squash_busy};
  assign obs_c = {if_c.PCSelF, if_c.StallF, if_c.StallD, if_c.FlushD, if_c.FlushE, if_c.squash_busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(posedge clk); #1;
    pcsrc = 2'b00; lw = 1'b0; rdy = 1'b1; rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    logic [6:0] e;
    do_reset();
    @(posedge clk); #1;
    pcsrc = 2'b01; rdy = 1'b1;
    @(posedge clk); #1;
    pcsrc = 2'b10; lw = 1'b1;
    #1;
    checks++;
    if (obs_a[0] !== 1'b1) begin
      errors++; $display("FAIL reset_pre_squash busy=%b want 1", obs_a[0]);
    end
    rst = 1'b0;
    sb_q.push_back(7'b00_0_0_1_1_0);
    #1;
    e = sb_q.pop_front();
    checks++;
    if (obs_a !== e) begin
      errors++; $display("FAIL reset_outputs got %b want %b", obs_a, e);
    end
    checks++;
    if (if_a.redirect_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_cnt got %0d want 0", if_a.redirect_cnt);
    end
    @(posedge clk); #1;
    checks++;
    if (if_a.redirect_cnt !== 16'd0 || obs_a !== 7'b00_0_0_1_1_0) begin
      errors++; $display("FAIL reset_hold cnt=%0d obs=%b want 0 0000110", if_a.redirect_cnt, obs_a);
    end
    pcsrc = 2'b00; lw = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (obs_a !== 7'b00_0_0_0_0_0) begin
      errors++; $display("FAIL reset_release got %b want 0000000", obs_a);
    end
  endtask

  task automatic test_branch();
    logic [1:0] p [3] = '{2'b01, 2'b00, 2'b00};
    logic [6:0] x [3] = '{7'b01_0_0_1_1_0, 7'b00_0_0_1_0_1, 7'b00_0_0_0_0_0};
    logic [6:0] e;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      pcsrc = p[i]; lw = 1'b0; rdy = 1'b1;
      sb_q.push_back(x[i]);
      @(negedge clk);
      e = sb_q.pop_front();
      checks++;
      if (obs_a !== e) begin
        errors++; $display("FAIL branch_c%0d got %b want %b", i, obs_a, e);
      end
    end
    checks++;
    if (if_a.redirect_cnt !== 16'd1) begin
      errors++; $display("FAIL branch_cnt got %0d want 1", if_a.redirect_cnt);
    end
  endtask

  task automatic test_load_use();
    logic       l [2] = '{1'b1, 1'b0};
    logic [6:0] x [2] = '{7'b00_1_1_0_1_0, 7'b00_0_0_0_0_0};
    logic [6:0] e;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      pcsrc = 2'b00; lw = l[i]; rdy = 1'b1;
      sb_q.push_back(x[i]);
      @(negedge clk);
      e = sb_q.pop_front();
      checks++;
      if (obs_a !== e) begin
        errors++; $display("FAIL load_use_c%0d got %b want %b", i, obs_a, e);
      end
    end
  endtask

  task automatic test_squash_lwstall();
    logic [1:0] p [3] = '{2'b01, 2'b00, 2'b00};
    logic       l [3] = '{1'b0, 1'b1, 1'b0};
    logic [6:0] x [3] = '{7'b01_0_0_1_1_0, 7'b00_1_0_1_1_1, 7'b00_0_0_0_0_0};
    logic [6:0] e;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      pcsrc = p[i]; lw = l[i]; rdy = 1'b1;
      sb_q.push_back(x[i]);
      @(negedge clk);
      e = sb_q.pop_front();
      checks++;
      if (obs_a !== e) begin
        errors++; $display("FAIL squash_lw_c%0d got %b want %b", i, obs_a, e);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [1:0] p [5] = '{2'b10, 2'b00, 2'b00, 2'b00, 2'b00};
    logic       l [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic       r [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [6:0] x [5] = '{7'b10_0_0_1_1_0, 7'b00_1_0_1_0_1, 7'b00_1_0_1_1_1,
                          7'b00_0_0_1_0_1, 7'b00_0_0_0_0_0};
    logic [6:0] e;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      pcsrc = p[i]; lw = l[i]; rdy = r[i];
      sb_q.push_back(x[i]);
      @(negedge clk);
      e = sb_q.pop_front();
      checks++;
      if (obs_a !== e) begin
        errors++; $display("FAIL simult_c%0d got %b want %b", i, obs_a, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] p [5] = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b00};
    logic [6:0] x [5] = '{7'b01_0_0_1_1_0, 7'b01_0_0_1_1_1, 7'b00_0_0_1_0_1,
                          7'b00_0_0_1_0_1, 7'b00_0_0_0_0_0};
    logic [6:0] e;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      pcsrc = p[i]; lw = 1'b0; rdy = 1'b1;
      sb_q.push_back(x[i]);
      @(negedge clk);
      e = sb_q.pop_front();
      checks++;
      if (obs_b !== e) begin
        errors++; $display("FAIL b2b_c%0d got %b want %b", i, obs_b, e);
      end
    end
    checks++;
    if (if_b.redirect_cnt !== 16'd2) begin
      errors++; $display("FAIL b2b_cnt got %0d want 2", if_b.redirect_cnt);
    end
  endtask

  task automatic test_saturation();
    logic [6:0] e;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      pcsrc = (i % 2 == 0) ? 2'b01 : 2'b10; lw = 1'b0; rdy = 1'b1;
    end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      pcsrc = 2'b00;
    end
    checks++;
    if (if_c.redirect_cnt !== 2'd3) begin
      errors++; $display("FAIL sat_cnt got %0d want 3", if_c.redirect_cnt);
    end
    @(posedge clk); #1;
    pcsrc = 2'b11; lw = 1'b0; rdy = 1'b1;
    sb_q.push_back(7'b00_0_0_0_0_0);
    @(negedge clk);
    e = sb_q.pop_front();
    checks++;
    if (obs_c !== e) begin
      errors++; $display("FAIL illegal_pcsrc got %b want %b", obs_c, e);
    end
    @(posedge clk); #1;
    pcsrc = 2'b00;
    checks++;
    if (if_a.redirect_cnt !== 16'd5 || if_c.redirect_cnt !== 2'd3) begin
      errors++; $display("FAIL illegal_no_count a=%0d c=%0d want 5 3", if_a.redirect_cnt, if_c.redirect_cnt);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    pcsrc  = 2'b00;
    lw     = 1'b0;
    rdy    = 1'b1;
    test_reset();
    test_branch();
    test_load_use();
    test_squash_lwstall();
    test_simultaneous();
    test_back_to_back();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
